// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader, instruction memory and fetch path.
// Holds the word and address widths the memory write port and fetch logic must agree on,
// the loader FSM state encoding and the width of the length header.
package loader_pkg;

  // Instruction width and byte-address width seen by instruction memory.
  localparam int WORD_W    = 18;
  localparam int ADDR_W    = 18;

  // Length header is a little-endian word count of this many bytes.
  localparam int LEN_BYTES = 2;
  localparam int CNT_W     = 8 * LEN_BYTES;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    B0   = 3'd3,
    B1   = 3'd4,
    B2   = 3'd5,
    CHK  = 3'd6,
    ERR  = 3'd7
  } loader_state_t;

  // States in which the loader is willing to take a stream byte.
  function automatic logic is_rx_state(input loader_state_t s);
    return (s inside {LEN0, LEN1, B0, B1, B2, CHK});
  endfunction

endpackage

// File: rtl/instruction_loader_xor_checksum.sv
// Purpose: 8-bit running XOR of accepted stream bytes, with synchronous clear.
// Latency: sum_o reflects a byte one cycle after en_i; clear also takes one cycle.
// Backpressure: none; the caller decides which bytes are folded in via en_i.
// Ports: clk/rst_n (sync, active low), clr_i zeroes the sum (wins over en_i),
//        en_i folds byte_i into the sum, sum_o is the current accumulator value.
module xor_checksum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = 8'h00;
    end else if (en_i) begin
      sum_d = sum_q ^ byte_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/instruction_loader.sv
// Purpose: frames a byte stream (length, payload, checksum) into 18-bit instruction writes.
// Latency: a write strobe appears one cycle after its third byte; throughput one byte/clock.
// Backpressure: byte_ready is low in IDLE and ERR; the sender must hold byte_valid until taken.
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   start                 one-cycle load request, honoured only when idle
//   byte_data/_valid/_ready  stream input handshake
//   wr_en/wr_addr/wr_data    instruction-memory write port (byte address, word aligned)
//   busy, cpu_hold        load in progress; cpu_hold keeps the core in reset
//   done, error           sticky outcome of the last load, cleared by the next start
module instruction_loader #(
  parameter int DEPTH  = 101,
  parameter int WORD_W = loader_pkg::WORD_W,
  parameter int ADDR_W = loader_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  import loader_pkg::*;

  // Word index must be able to hold DEPTH itself (the value after the last write).
  localparam int IDX_W = $clog2(DEPTH + 1);

  loader_state_t     state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [15:0]       data_lo_q, data_lo_d;
  logic              byte_ready_q, byte_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              fire;
  logic              cks_clr;
  logic              cks_en;
  logic [7:0]        cks_sum;
  logic [CNT_W-1:0]  hdr_count;
  logic [IDX_W-1:0]  index_inc;

  // byte_ready is a register, so the handshake depends only on state already committed.
  assign fire      = byte_valid && byte_ready_q;
  assign hdr_count = {byte_data, count_q[7:0]};
  assign index_inc = index_q + IDX_W'(1);

  xor_checksum u_cks (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cks_clr),
    .en_i   (cks_en),
    .byte_i (byte_data),
    .sum_o  (cks_sum)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    index_d   = index_q;
    data_lo_d = data_lo_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    error_d   = error_q;
    cks_clr   = 1'b0;
    cks_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          index_d = '0;
          cks_clr = 1'b1;
          state_d = LEN0;
        end
      end

      LEN0: begin
        if (fire) begin
          count_d[7:0] = byte_data;
          cks_en       = 1'b1;
          state_d      = LEN1;
        end
      end

      LEN1: begin
        if (fire) begin
          count_d = hdr_count;
          cks_en  = 1'b1;
          // An empty or oversized program is rejected before any write is issued.
          if ((hdr_count == '0) || (hdr_count > CNT_W'(DEPTH))) begin
            state_d = ERR;
          end else begin
            state_d = B0;
          end
        end
      end

      B0: begin
        if (fire) begin
          data_lo_d[7:0] = byte_data;
          cks_en         = 1'b1;
          state_d        = B1;
        end
      end

      B1: begin
        if (fire) begin
          data_lo_d[15:8] = byte_data;
          cks_en          = 1'b1;
          state_d         = B2;
        end
      end

      B2: begin
        if (fire) begin
          cks_en    = 1'b1;
          // Only the low two bits of the third byte belong to the instruction.
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_W'({index_q, 2'b00});
          wr_data_d = WORD_W'({byte_data[1:0], data_lo_q});
          index_d   = index_inc;
          if (CNT_W'(index_inc) == count_q) begin
            state_d = CHK;
          end else begin
            state_d = B0;
          end
        end
      end

      CHK: begin
        if (fire) begin
          if (byte_data == cks_sum) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ERR;
          end
        end
      end

      ERR: begin
        error_d = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Both flags follow the next state so they line up with it cycle for cycle.
    byte_ready_d = is_rx_state(state_d);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      index_q      <= '0;
      data_lo_q    <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      index_q      <= index_d;
      data_lo_q    <= data_lo_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign cpu_hold   = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed scenarios plus randomized loads,
// each checked against a reference model that parses the byte stream by the framing rules.
module tb_instruction_loader;

  localparam int DEPTH = 101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [17:0] wr_addr;
  logic [17:0] wr_data;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] stream[$];
  int         exp_addr[$];
  int         exp_data[$];
  bit         exp_done;
  bit         exp_err;
  int         obs_addr[$];
  int         obs_data[$];
  int         obs_cyc[$];

  instruction_loader #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      obs_addr.push_back(int'(wr_addr));
      obs_data.push_back(int'(wr_data));
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: interpret the stream by the framing rules.
  function automatic void model();
    int         cnt;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    cnt = int'(stream[0]) + 256 * int'(stream[1]);
    if (cnt == 0 || cnt > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < 2 + 3 * cnt; i++) x = x ^ stream[i];
    for (int w = 0; w < cnt; w++) begin
      exp_addr.push_back(4 * w);
      exp_data.push_back(int'(stream[2 + 3*w]) + 256 * int'(stream[3 + 3*w])
                         + 65536 * (int'(stream[4 + 3*w]) % 4));
    end
    if (stream[2 + 3*cnt] == x) exp_done = 1'b1;
    else exp_err = 1'b1;
  endfunction

  // Stimulus builder: header, random payload, correct or corrupted checksum.
  task automatic build(input int cnt, input bit bad);
    logic [15:0] c;
    logic [7:0]  b;
    logic [7:0]  x;
    c = 16'(cnt);
    stream.delete();
    stream.push_back(c[7:0]);
    stream.push_back(c[15:8]);
    if (cnt >= 1 && cnt <= DEPTH) begin
      x = c[7:0] ^ c[15:8];
      for (int i = 0; i < 3 * cnt; i++) begin
        b = 8'($urandom);
        stream.push_back(b);
        x = x ^ b;
      end
      if (bad) x = x ^ (8'h01 << $urandom_range(0, 7));
      stream.push_back(x);
    end
  endtask

  // Enters and leaves at a falling edge; the byte transfers on the rising edge in between.
  task automatic send_byte(input logic [7:0] b, input int max_gap, input bit pulse, output bit ok);
    int n;
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    start      = pulse;
    n = 0;
    while (byte_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 100);
    if (!ok) begin
      tests++;
      fails++;
      $error("FAIL handshake: byte_ready observed low for 100 cycles, required 1");
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy_up"}, busy, 1);
    check({tag, ".hold_up"}, cpu_hold, 1);
    check({tag, ".done_clr"}, done, 0);
    check({tag, ".err_clr"}, error, 0);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".idle"}, busy, 0);
  endtask

  task automatic compare_results(input string tag);
    int n;
    check({tag, ".nwr"}, obs_addr.size(), exp_addr.size());
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.addr%0d", tag, i), obs_addr[i], exp_addr[i]);
      check($sformatf("%s.data%0d", tag, i), obs_data[i], exp_data[i]);
    end
    check({tag, ".done"}, done, exp_done);
    check({tag, ".error"}, error, exp_err);
    check({tag, ".hold"}, cpu_hold, 0);
    check({tag, ".ready"}, byte_ready, 0);
  endtask

  task automatic run_load(input string tag, input int max_gap, input int start_at);
    bit ok;
    model();
    clear_obs();
    pulse_start(tag);
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i], max_gap, (i == start_at), ok);
      if (!ok) break;
    end
    wait_idle(tag, 2);
    compare_results(tag);
  endtask

  initial begin
    bit ok;
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst.byte_ready", byte_ready, 0);
    check("rst.wr_en", wr_en, 0);
    check("rst.wr_addr", wr_addr, 0);
    check("rst.wr_data", wr_data, 0);
    check("rst.busy", busy, 0);
    check("rst.cpu_hold", cpu_hold, 0);
    check("rst.done", done, 0);
    check("rst.error", error, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed two-word load, write strobe checked the cycle after each third byte
    stream = {8'h02, 8'h00, 8'hE0, 8'h11, 8'h02, 8'hE0, 8'h11, 8'h02, 8'h02};
    model();
    clear_obs();
    pulse_start("two");
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i], 0, 1'b0, ok);
      if (i == 4 || i == 7) check($sformatf("two.wr_en_after_b2_%0d", i), wr_en, 1);
      if (i == 5) check("two.wr_en_one_cycle", wr_en, 0);
    end
    wait_idle("two", 2);
    compare_results("two");
    if (obs_data.size() == 2) begin
      check("two.const_data0", obs_data[0], 32'h211E0);
      check("two.const_addr1", obs_addr[1], 32'h4);
    end else begin
      check("two.const_nwr", obs_data.size(), 2);
    end

    // Bad lengths: zero, one past capacity, high header byte set
    stream = {8'h00, 8'h00};
    run_load("len0", 1, -1);
    stream = {8'h66, 8'h00};
    run_load("len102", 1, -1);
    build(257, 1'b0);
    run_load("len257", 0, -1);

    // Checksum mismatch on a single-word load
    build(1, 1'b1);
    run_load("badchk", 1, -1);

    // Full-capacity load
    build(DEPTH, 1'b0);
    run_load("full", 0, -1);

    // Randomized loads, some with corrupted checksums
    for (int k = 0; k < 6; k++) begin
      build($urandom_range(1, 12), ($urandom_range(0, 3) == 0));
      run_load($sformatf("rnd%0d", k), 2, -1);
    end

    // Reset during B1 of the third word
    build(5, 1'b0);
    clear_obs();
    pulse_start("midrst");
    for (int i = 0; i < 9; i++) send_byte(stream[i], 0, 1'b0, ok);
    rst_n      = 1'b0;
    byte_valid = 1'b1;
    byte_data  = stream[9];
    @(negedge clk);
    byte_valid = 1'b0;
    check("midrst.byte_ready", byte_ready, 0);
    check("midrst.wr_en", wr_en, 0);
    check("midrst.wr_addr", wr_addr, 0);
    check("midrst.wr_data", wr_data, 0);
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.error", error, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst.nwr", obs_addr.size(), 2);
    build(9, 1'b0);
    run_load("after_rst", 1, -1);
    if (obs_addr.size() == 9) check("after_rst.last_addr", obs_addr[8], 32'h20);
    else check("after_rst.nwr9", obs_addr.size(), 9);

    // Back-to-back bytes with a start pulse in the middle of the load
    build(3, 1'b0);
    run_load("b2b", 0, 5);
    if (obs_cyc.size() == 3) begin
      check("b2b.space01", obs_cyc[1] - obs_cyc[0], 3);
      check("b2b.space12", obs_cyc[2] - obs_cyc[1], 3);
    end else begin
      check("b2b.nwr3", obs_cyc.size(), 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
